fifo_word_unpacker: RTL

- Drains the dequeue side of an upstream sized FIFO (EMPTY_N / D_OUT / DEQ) and splits each wide word into p2ratio narrow beats.
- Presents the beats on its own FIFO-style dequeue interface (EMPTY_N / D_OUT / DEQ / CLR), so downstream logic sees an ordinary FIFO.
- Sits between a wide datapath FIFO and a narrow consumer; sustains one beat per cycle, including across word boundaries.

---
 rtl/fifo_word_unpacker_pkg.sv | 30 +++
 rtl/fifo_word_unpacker.sv | 76 +++++++
 2 files changed

// File: rtl/fifo_word_unpacker_pkg.sv
// Shared FIFO-family helpers: reset polarity/edge macros and a beat-select function.
// Beat select is width-generic so a future packer can reuse it on the same word/beat layout.
`ifndef FIFO_WORD_UNPACKER_PKG_SV
`define FIFO_WORD_UNPACKER_PKG_SV

`define FIFO_RST_EDGE(r) negedge r
`define FIFO_RST_ACTIVE(r) (!(r))

package fifo_word_unpacker_pkg;

   localparam int unsigned MAX_WORD_W = 256;
   localparam int unsigned MAX_BEAT_W = 64;

   typedef logic [MAX_WORD_W-1:0] word_t;
   typedef logic [MAX_BEAT_W-1:0] beat_t;

   // Callers truncate the result to their own beat width; bits above it are neighbouring beats.
   function automatic beat_t beat_select(input word_t word, input int unsigned idx,
                                         input int unsigned ratio, input int unsigned beat_w,
                                         input logic lsb_first);
      int unsigned slot;
      word_t       shifted;
      slot    = lsb_first ? idx : (ratio - 1 - idx);
      shifted = word >> (slot * beat_w);
      return shifted[MAX_BEAT_W-1:0];
   endfunction

endpackage

`endif

// File: rtl/fifo_word_unpacker.sv
// Splits each upstream FIFO word into p2ratio beats behind a FIFO-style dequeue port; beat 0 one cycle after IN_DEQ.
// Backpressure: DEQ low holds the current beat and blocks upstream dequeue; last beat + DEQ reloads with no bubble.
module fifo_word_unpacker
   import fifo_word_unpacker_pkg::*;
#(
   parameter int p1width      = 32,
   parameter int p2ratio      = 4,
   parameter int p3cntr_width = 2,
   parameter int p4beat_width = 8,
   parameter bit lsb_first    = 1'b1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    IN_EMPTY_N,
   input  logic [p1width-1:0]      IN_D,
   output logic                    IN_DEQ,
   output logic [p4beat_width-1:0] D_OUT,
   output logic                    EMPTY_N,
   output logic                    LAST,
   input  logic                    DEQ,
   input  logic                    CLR
);

   localparam logic [p3cntr_width-1:0] CNT_LAST = p3cntr_width'(p2ratio - 1);

   if (p2ratio < 2) begin : g_bad_ratio
      $fatal(1, "fifo_word_unpacker: p2ratio must be >= 2");
   end
   if (p1width != p2ratio * p4beat_width) begin : g_bad_width
      $fatal(1, "fifo_word_unpacker: p1width must equal p2ratio*p4beat_width");
   end
   if ((2 ** p3cntr_width) < p2ratio) begin : g_bad_cntr
      $fatal(1, "fifo_word_unpacker: p3cntr_width too small for p2ratio");
   end

   logic [p1width-1:0]      hold;
   logic [p3cntr_width-1:0] cnt;
   logic                    hasdata;
   logic                    last;
   logic                    load;

   assign last    = hasdata && (cnt == CNT_LAST);
   assign load    = !CLR && IN_EMPTY_N && (!hasdata || (DEQ && last));
   // Gate with RST so the upstream FIFO is never popped while we are held in reset.
   assign IN_DEQ  = load && RST;
   assign EMPTY_N = hasdata;
   assign LAST    = last;
   assign D_OUT   = p4beat_width'(beat_select(word_t'(hold), 32'(cnt), p2ratio,
                                              p4beat_width, lsb_first));

   always_ff @(posedge CLK or `FIFO_RST_EDGE(RST)) begin
      if (`FIFO_RST_ACTIVE(RST)) begin
         hold    <= '0;
         cnt     <= '0;
         hasdata <= 1'b0;
      end else if (CLR) begin
         cnt     <= '0;
         hasdata <= 1'b0;
      end else if (load) begin
         hold    <= IN_D;
         cnt     <= '0;
         hasdata <= 1'b1;
      end else if (DEQ && hasdata && !last) begin
         cnt     <= cnt + 1'b1;
      end else if (DEQ && last && !IN_EMPTY_N) begin
         cnt     <= '0;
         hasdata <= 1'b0;
      end
   end

   always @(posedge CLK) begin
      if (RST && DEQ && !hasdata)
         $warning("fifo_word_unpacker: %m -- Dequeuing from empty unpacker");
   end

endmodule
